// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcode constants, the canonical NOP and the
// fetch-stage state encoding.
package riscv_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // Word-align an address by clearing its two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_fetch_hold_buf.sv
// One-entry {pc, instr} buffer that parks a fetched instruction while the
// IF/ID register is stalled.
module fetch_hold_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// buffers a response across decode stalls and discards responses after redirects.
module if_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic [6:0]      ifid_opcode
);

    // Handshake: a request transfers in any cycle where imem_req_valid and
    // imem_req_ready are both high; responses arrive as single-cycle pulses
    // of imem_rsp_valid and are never back-pressured.

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic            ifid_load, ifid_flush;
    logic [XLEN-1:0] ifid_load_pc;
    logic [31:0]     ifid_load_instr;

    logic            buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_instr;

    logic            ifid_free;
    assign ifid_free = !ifid_valid || !stall;

    fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (pc_q),
        .load_instr (imem_rsp_data),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_load       = 1'b0;
        ifid_flush      = 1'b0;
        ifid_load_pc    = pc_q;
        ifid_load_instr = imem_rsp_data;
        buf_load        = 1'b0;
        buf_clear       = 1'b0;

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~XLEN'(3);
            ifid_flush = 1'b1;
            buf_clear  = 1'b1;
            unique case (state_q)
                REQ:     state_d = imem_req_ready ? DROP : REQ;
                WAIT:    state_d = imem_rsp_valid ? REQ : DROP;
                HOLD:    state_d = REQ;
                // A response landing with the redirect retires the outstanding request.
                DROP:    state_d = imem_rsp_valid ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_req_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (ifid_free) begin
                            ifid_load = 1'b1;
                            pc_d      = pc_q + XLEN'(4);
                            state_d   = REQ;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall && buf_valid) begin
                        ifid_load       = 1'b1;
                        ifid_load_pc    = buf_pc;
                        ifid_load_instr = buf_instr;
                        buf_clear       = 1'b1;
                        pc_d            = pc_q + XLEN'(4);
                        state_d         = REQ;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) state_d = REQ;
                end
                default: state_d = REQ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        imem_req_valid = (state_q == REQ);
        imem_req_addr  = pc_q;
    end

    // IF/ID register: flush beats stall, stall freezes, otherwise consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid  <= 1'b0;
            ifid_pc     <= '0;
            ifid_instr  <= NOP_INSTR;
            ifid_opcode <= NOP_INSTR[6:0];
        end else if (ifid_flush) begin
            ifid_valid  <= 1'b0;
            ifid_instr  <= NOP_INSTR;
            ifid_opcode <= NOP_INSTR[6:0];
        end else if (ifid_load) begin
            ifid_valid  <= 1'b1;
            ifid_pc     <= ifid_load_pc;
            ifid_instr  <= ifid_load_instr;
            ifid_opcode <= ifid_load_instr[6:0];
        end else if (!stall) begin
            ifid_valid  <= 1'b0;
            ifid_instr  <= NOP_INSTR;
            ifid_opcode <= NOP_INSTR[6:0];
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: walks the fetch FSM through reset, stall,
// redirect, back-pressure, PC wrap and asynchronous reset.
module tb_if_stage;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic [6:0]      ifid_opcode;

    int n_cmp  = 0;
    int n_fail = 0;

    if_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr),
        .ifid_opcode    (ifid_opcode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [6:0] opc);
        chk({tag, ".valid"},  32'(ifid_valid),  32'(v));
        chk({tag, ".pc"},     ifid_pc,          pc);
        chk({tag, ".instr"},  ifid_instr,       instr);
        chk({tag, ".opcode"}, 32'(ifid_opcode), 32'(opc));
    endtask

    initial begin
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst.req_addr", imem_req_addr, 32'h100);
        chk_ifid("rst.ifid", 1'b0, 32'h0, 32'h0000_0013, 7'h13);

        // First fetch with zero-wait memory
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        chk("first.req_valid_wait", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        tick();
        imem_rsp_valid = 1'b0;
        chk_ifid("first.ifid", 1'b1, 32'h100, 32'h0050_0093, 7'h13);
        chk("first.next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first.next_addr", imem_req_addr, 32'h104);

        // Stall while a response arrives
        stall = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk_ifid("stall.held0", 1'b1, 32'h100, 32'h0050_0093, 7'h13);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0113;
        tick();
        imem_rsp_valid = 1'b0;
        chk("stall.hold_noreq1", 32'(imem_req_valid), 32'd0);
        chk_ifid("stall.held1", 1'b1, 32'h100, 32'h0050_0093, 7'h13);
        tick();
        chk("stall.hold_noreq2", 32'(imem_req_valid), 32'd0);
        tick();
        chk("stall.hold_noreq3", 32'(imem_req_valid), 32'd0);
        chk_ifid("stall.held3", 1'b1, 32'h100, 32'h0050_0093, 7'h13);
        stall = 1'b0;
        tick();
        chk_ifid("stall.release", 1'b1, 32'h104, 32'h00A0_0113, 7'h13);
        chk("stall.next_addr", imem_req_addr, 32'h108);
        chk("stall.next_req_valid", 32'(imem_req_valid), 32'd1);

        // Consume, then redirect while in WAIT
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk_ifid("consume", 1'b0, 32'h104, 32'h0000_0013, 7'h13);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        chk("redir.drop_noreq", 32'(imem_req_valid), 32'd0);
        chk("redir.flush_valid", 32'(ifid_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("redir.discard_valid", 32'(ifid_valid), 32'd0);
        chk("redir.discard_instr", ifid_instr, 32'h0000_0013);
        chk("redir.req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir.req_addr", imem_req_addr, 32'h2000);

        // Load an R-type, then redirect while stalled with IF/ID live
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_81B3;
        tick();
        imem_rsp_valid = 1'b0;
        chk_ifid("rtype", 1'b1, 32'h2000, 32'h0020_81B3, 7'h33);
        chk("rtype.next_addr", imem_req_addr, 32'h2004);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("redir_stall.valid", 32'(ifid_valid), 32'd0);
        chk("redir_stall.instr", ifid_instr, 32'h0000_0013);
        chk("redir_stall.opcode", 32'(ifid_opcode), 32'h13);
        chk("redir_stall.addr", imem_req_addr, 32'h3000);

        // Back-pressure: ready low for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d.req_valid", i), 32'(imem_req_valid), 32'd1);
            chk($sformatf("bp%0d.addr", i), imem_req_addr, 32'h3000);
            chk($sformatf("bp%0d.ifid_valid", i), 32'(ifid_valid), 32'd0);
        end

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk("wrap.addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_2083;
        tick();
        imem_rsp_valid = 1'b0;
        chk_ifid("wrap.ifid", 1'b1, 32'hFFFF_FFFC, 32'h0000_2083, 7'h03);
        chk("wrap.next_addr", imem_req_addr, 32'h0000_0000);

        // Asynchronous reset while waiting for a response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("areset.pre_wait", 32'(imem_req_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.req_valid", 32'(imem_req_valid), 32'd1);
        chk("areset.req_addr", imem_req_addr, 32'h100);
        chk_ifid("areset.ifid", 1'b0, 32'h0, 32'h0000_0013, 7'h13);
        tick();
        rst_n = 1'b1;
        tick();
        chk("areset.after_release_addr", imem_req_addr, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
